// File: rtl/tweak_pulse_gen.sv
// Multi-channel tweak pulse generator: after each pwm edge, waits a global delay and then
// fires one delayed pulse per enabled channel. Define TWEAK_LONG_PULSE_EN for 4x pulse lengths.
module tweak_pulse_gen #(
    parameter int NO_TWEAKS      = 6,
    parameter int DELAY_WIDTH    = 3,
    parameter int DURATION_WIDTH = 2,
    parameter int GLOBAL_WIDTH   = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                pwm,
    input  logic [GLOBAL_WIDTH-1:0]             tweak_global_delay,
    input  logic [NO_TWEAKS-1:0]                tweak_enable,
    input  logic [NO_TWEAKS-1:0]                tweak_sense,
    input  logic [NO_TWEAKS*DELAY_WIDTH-1:0]    tweak_delay,
    input  logic [NO_TWEAKS*DURATION_WIDTH-1:0] tweak_duration,
    output logic [NO_TWEAKS-1:0]                tweak_out,
    output logic                                busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_GDELAY = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT  = 2'd0,
        PH_PULSE = 2'd1,
        PH_DONE  = 2'd2
    } phase_t;

    localparam logic [GLOBAL_WIDTH:0]   GCNT_ONE = {{GLOBAL_WIDTH{1'b0}}, 1'b1};
    localparam logic [DELAY_WIDTH:0]    DCNT_ONE = {{DELAY_WIDTH{1'b0}}, 1'b1};
    localparam logic [DURATION_WIDTH:0] LCNT_ONE = {{DURATION_WIDTH{1'b0}}, 1'b1};

    state_t                              r_state, w_state_nx;
    logic                                r_pwm_prev, r_prev_valid, r_edge, w_edge;
    logic [GLOBAL_WIDTH:0]               r_gcnt, w_gcnt_nx, w_gcnt_inc;
    logic [GLOBAL_WIDTH-1:0]             r_snap_gdelay, w_snap_gdelay_nx;
    logic [NO_TWEAKS-1:0]                r_snap_enable, w_snap_enable_nx;
    logic [NO_TWEAKS-1:0]                r_snap_sense, w_snap_sense_nx;
    logic [NO_TWEAKS*DELAY_WIDTH-1:0]    r_snap_delay, w_snap_delay_nx;
    logic [NO_TWEAKS*DURATION_WIDTH-1:0] r_snap_duration, w_snap_duration_nx;
    phase_t                              r_phase [NO_TWEAKS];
    phase_t                              w_phase_nx [NO_TWEAKS];
    logic [DELAY_WIDTH:0]                r_dcnt [NO_TWEAKS];
    logic [DELAY_WIDTH:0]                w_dcnt_nx [NO_TWEAKS];
    logic [DURATION_WIDTH:0]             r_lcnt [NO_TWEAKS];
    logic [DURATION_WIDTH:0]             w_lcnt_nx [NO_TWEAKS];
`ifdef TWEAK_LONG_PULSE_EN
    logic [1:0]                          r_presc [NO_TWEAKS];
    logic [1:0]                          w_presc_nx [NO_TWEAKS];
`endif
    logic [NO_TWEAKS-1:0]                r_out, w_out_nx;
    logic                                r_busy, w_busy_nx, w_all_done;

    // The valid flag keeps the first cycle after reset from reporting a spurious edge.
    assign w_edge     = r_prev_valid & (pwm ^ r_pwm_prev);
    assign w_gcnt_inc = r_gcnt + GCNT_ONE;
    assign tweak_out  = r_out;
    assign busy       = r_busy;

    // pwm edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_prev   <= 1'b0;
            r_prev_valid <= 1'b0;
            r_edge       <= 1'b0;
        end else begin
            r_pwm_prev   <= pwm;
            r_prev_valid <= 1'b1;
            r_edge       <= w_edge;
        end
    end

    // State, snapshot, per-channel counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_gcnt          <= '0;
            r_snap_gdelay   <= '0;
            r_snap_enable   <= '0;
            r_snap_sense    <= '0;
            r_snap_delay    <= '0;
            r_snap_duration <= '0;
            r_out           <= '0;
            r_busy          <= 1'b0;
            for (int i = 0; i < NO_TWEAKS; i++) begin
                r_phase[i] <= PH_DONE;
                r_dcnt[i]  <= '0;
                r_lcnt[i]  <= '0;
`ifdef TWEAK_LONG_PULSE_EN
                r_presc[i] <= 2'd0;
`endif
            end
        end else begin
            r_state         <= w_state_nx;
            r_gcnt          <= w_gcnt_nx;
            r_snap_gdelay   <= w_snap_gdelay_nx;
            r_snap_enable   <= w_snap_enable_nx;
            r_snap_sense    <= w_snap_sense_nx;
            r_snap_delay    <= w_snap_delay_nx;
            r_snap_duration <= w_snap_duration_nx;
            r_out           <= w_out_nx;
            r_busy          <= w_busy_nx;
            r_phase         <= w_phase_nx;
            r_dcnt          <= w_dcnt_nx;
            r_lcnt          <= w_lcnt_nx;
`ifdef TWEAK_LONG_PULSE_EN
            r_presc         <= w_presc_nx;
`endif
        end
    end

    // Next-state: sequencing, snapshot capture and per-channel pulse timing
    always_comb begin
        w_state_nx         = r_state;
        w_gcnt_nx          = r_gcnt;
        w_snap_gdelay_nx   = r_snap_gdelay;
        w_snap_enable_nx   = r_snap_enable;
        w_snap_sense_nx    = r_snap_sense;
        w_snap_delay_nx    = r_snap_delay;
        w_snap_duration_nx = r_snap_duration;
        w_phase_nx         = r_phase;
        w_dcnt_nx          = r_dcnt;
        w_lcnt_nx          = r_lcnt;
`ifdef TWEAK_LONG_PULSE_EN
        w_presc_nx         = r_presc;
`endif
        w_out_nx           = r_out;
        w_busy_nx          = r_busy;
        w_all_done         = 1'b1;

        if (r_edge) begin
            // A new edge restarts from scratch, whatever state we were in.
            w_state_nx = ST_ALIGN;
            w_busy_nx  = 1'b1;
            w_out_nx   = r_snap_sense;
            for (int i = 0; i < NO_TWEAKS; i++) begin
                w_phase_nx[i] = PH_DONE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_busy_nx = 1'b0;
                end
                ST_ALIGN: begin
                    w_snap_gdelay_nx   = tweak_global_delay;
                    w_snap_enable_nx   = tweak_enable;
                    w_snap_sense_nx    = tweak_sense;
                    w_snap_delay_nx    = tweak_delay;
                    w_snap_duration_nx = tweak_duration;
                    w_out_nx           = tweak_sense;
                    w_gcnt_nx          = '0;
                    for (int i = 0; i < NO_TWEAKS; i++) begin
                        w_phase_nx[i] = tweak_enable[i] ? PH_WAIT : PH_DONE;
                        w_dcnt_nx[i]  = '0;
                        w_lcnt_nx[i]  = '0;
                    end
                    if (tweak_global_delay == {GLOBAL_WIDTH{1'b0}}) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_GDELAY;
                    end
                end
                ST_GDELAY: begin
                    if (w_gcnt_inc == {1'b0, r_snap_gdelay}) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_gcnt_nx = w_gcnt_inc;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NO_TWEAKS; i++) begin
                        case (r_phase[i])
                            PH_WAIT: begin
                                w_all_done = 1'b0;
                                if (r_dcnt[i] == {1'b0, r_snap_delay[i*DELAY_WIDTH +: DELAY_WIDTH]}) begin
                                    w_out_nx[i]   = ~r_snap_sense[i];
                                    w_phase_nx[i] = PH_PULSE;
                                    w_lcnt_nx[i]  = '0;
`ifdef TWEAK_LONG_PULSE_EN
                                    w_presc_nx[i] = 2'd0;
`endif
                                end else begin
                                    w_dcnt_nx[i] = r_dcnt[i] + DCNT_ONE;
                                end
                            end
                            PH_PULSE: begin
`ifdef TWEAK_LONG_PULSE_EN
                                // Duration counter advances once per four prescaler ticks.
                                if (r_presc[i] == 2'd3) begin
                                    if (r_lcnt[i] == {1'b0, r_snap_duration[i*DURATION_WIDTH +: DURATION_WIDTH]}) begin
                                        w_out_nx[i]   = r_snap_sense[i];
                                        w_phase_nx[i] = PH_DONE;
                                    end else begin
                                        w_all_done    = 1'b0;
                                        w_lcnt_nx[i]  = r_lcnt[i] + LCNT_ONE;
                                        w_presc_nx[i] = 2'd0;
                                    end
                                end else begin
                                    w_all_done    = 1'b0;
                                    w_presc_nx[i] = r_presc[i] + 2'd1;
                                end
`else
                                if (r_lcnt[i] == {1'b0, r_snap_duration[i*DURATION_WIDTH +: DURATION_WIDTH]}) begin
                                    w_out_nx[i]   = r_snap_sense[i];
                                    w_phase_nx[i] = PH_DONE;
                                end else begin
                                    w_all_done   = 1'b0;
                                    w_lcnt_nx[i] = r_lcnt[i] + LCNT_ONE;
                                end
`endif
                            end
                            PH_DONE: begin
                                w_out_nx[i] = r_snap_sense[i];
                            end
                            default: begin
                                w_out_nx[i]   = r_snap_sense[i];
                                w_phase_nx[i] = PH_DONE;
                            end
                        endcase
                    end
                    // busy drops on the same edge the last pulse returns to idle.
                    if (w_all_done) begin
                        w_state_nx = ST_IDLE;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_busy_nx  = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule
